sha256_multiblock_engine: RTL

//  Parametrised next-generation SHA-256 engine. Reads a word-aligned message of any length from

---
 rtl/sha256_multiblock_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_multiblock_engine.sv
// rtl/sha256_multiblock_engine.sv - multi-block SHA-256 engine with midstate resume on a shared word memory port
module sha256_multiblock_engine #(
   parameter int NUM_OF_WORDS = 20,
   parameter int OUT_WORDS    = 8,
   parameter int PREFIX_BITS  = 512
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         use_midstate,
   input  logic [255:0] midstate_in,
   input  logic [15:0]  message_addr,
   input  logic [15:0]  output_addr,
   output logic         done,
   output logic         mem_clk,
   output logic         mem_we,
   output logic [15:0]  mem_addr,
   output logic [31:0]  mem_write_data,
   input  logic [31:0]  mem_read_data
);
   localparam int         NB       = (NUM_OF_WORDS + 2) / 16 + 1;
   localparam logic [6:0] LAST_BLK = 7'(NB - 1);
   localparam logic [6:0] LAST_OUT = 7'(OUT_WORDS - 1);
   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [2047:0] K_TABLE = {
      256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
      256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
      256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
      256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
      256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
      256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
      256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
      256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2};

   typedef enum logic [2:0] {S_IDLE, S_READ, S_PAD, S_COMPUTE, S_UPDATE, S_WRITE} state_t;

   state_t       r_state, w_next;
   logic [6:0]   r_block, r_cnt;
   logic         r_use_mid;
   logic [15:0]  r_msg_addr, r_out_addr;
   logic [31:0]  r_h [8];
   logic [31:0]  r_v [8];
   logic [31:0]  r_w [16];
   logic         r_we;
   logic [15:0]  r_addr;
   logic [31:0]  r_wd;
   logic         w_we_d;
   logic [15:0]  w_addr_d;
   logic [31:0]  w_wd_d;
   logic [4:0]   w_rcnt, w_rcnt_nxt;
   logic [2:0]   w_widx;
   logic [63:0]  w_len;
   logic [31:0]  w_k, w_t1, w_t2, w_wnew;

   function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Words fetched from memory for block b (0 for padding-only blocks).
   function automatic logic [4:0] f_words(input logic [6:0] b);
      int rem;
      rem = NUM_OF_WORDS - 16 * int'(b);
      if (rem <= 0)       return 5'd0;
      else if (rem >= 16) return 5'd16;
      else                return 5'(rem);
   endfunction

   assign mem_clk        = clk;
   assign done           = (r_state == S_IDLE);
   assign mem_we         = r_we;
   assign mem_addr       = r_addr;
   assign mem_write_data = r_wd;

   assign w_rcnt     = f_words(r_block);
   assign w_rcnt_nxt = f_words(r_block + 7'd1);
   assign w_widx     = r_cnt[2:0] + 3'd1;
   assign w_len      = 64'(NUM_OF_WORDS) * 64'd32 + (r_use_mid ? 64'(PREFIX_BITS) : 64'd0);
   assign w_k        = K_TABLE[(63 - int'(r_cnt[5:0])) * 32 +: 32];
   assign w_t1       = r_v[7] + (f_rotr(r_v[4], 6) ^ f_rotr(r_v[4], 11) ^ f_rotr(r_v[4], 25))
                     + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + w_k + r_w[0];
   assign w_t2       = (f_rotr(r_v[0], 2) ^ f_rotr(r_v[0], 13) ^ f_rotr(r_v[0], 22))
                     + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
   assign w_wnew     = (f_rotr(r_w[14], 17) ^ f_rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
                     + (f_rotr(r_w[1], 7) ^ f_rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode; padding-only blocks bypass READ
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_READ;
         S_READ:    if (r_cnt == {2'b00, w_rcnt}) w_next = S_PAD;
         S_PAD:     w_next = S_COMPUTE;
         S_COMPUTE: if (r_cnt == 7'd63) w_next = S_UPDATE;
         S_UPDATE:  if (r_block != LAST_BLK) w_next = (w_rcnt_nxt != 5'd0) ? S_READ : S_PAD;
                    else                     w_next = S_WRITE;
         S_WRITE:   if (r_cnt == LAST_OUT) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Next values of the registered memory port, so each value lands in the cycle it belongs to
   always_comb begin
      w_we_d   = 1'b0;
      w_addr_d = r_addr;
      w_wd_d   = r_wd;
      case (r_state)
         S_IDLE:   if (start) w_addr_d = message_addr;
         S_READ:   if ({2'b00, w_rcnt} > r_cnt + 7'd1) w_addr_d = r_addr + 16'd1;
         S_UPDATE: begin
            if (r_block != LAST_BLK) begin
               if (w_rcnt_nxt != 5'd0) w_addr_d = r_msg_addr + {5'b00000, r_block + 7'd1, 4'b0000};
            end else begin
               w_we_d   = 1'b1;
               w_addr_d = r_out_addr;
               w_wd_d   = r_h[0] + r_v[0];
            end
         end
         S_WRITE:  if (r_cnt != LAST_OUT) begin
            w_we_d   = 1'b1;
            w_addr_d = r_addr + 16'd1;
            w_wd_d   = r_h[w_widx];
         end
         default: ;
      endcase
   end

   // Datapath: capture, padding, rounds, chaining-value update, port registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= 7'd0;
         r_block    <= 7'd0;
         r_use_mid  <= 1'b0;
         r_msg_addr <= 16'd0;
         r_out_addr <= 16'd0;
         r_we       <= 1'b0;
         r_addr     <= 16'd0;
         r_wd       <= 32'd0;
         for (int i = 0; i < 8; i++) begin
            r_h[i] <= 32'd0;
            r_v[i] <= 32'd0;
         end
         for (int i = 0; i < 16; i++) r_w[i] <= 32'd0;
      end else begin
         r_we   <= w_we_d;
         r_addr <= w_addr_d;
         r_wd   <= w_wd_d;
         r_cnt  <= (w_next != r_state) ? 7'd0 : r_cnt + 7'd1;
         case (r_state)
            S_IDLE: if (start) begin
               r_use_mid  <= use_midstate;
               r_msg_addr <= message_addr;
               r_out_addr <= output_addr;
               r_block    <= 7'd0;
               for (int i = 0; i < 8; i++)
                  r_h[i] <= use_midstate ? midstate_in[255 - 32 * i -: 32] : IV[255 - 32 * i -: 32];
            end
            S_READ: if (r_cnt != 7'd0) r_w[4'(r_cnt - 7'd1)] <= mem_read_data;
            S_PAD: begin
               for (int i = 0; i < 16; i++) begin
                  if (i >= int'(w_rcnt))
                     r_w[i] <= (int'(r_block) * 16 + i == NUM_OF_WORDS) ? 32'h8000_0000 : 32'h0;
               end
               if (r_block == LAST_BLK) begin
                  r_w[14] <= w_len[63:32];
                  r_w[15] <= w_len[31:0];
               end
               for (int i = 0; i < 8; i++) r_v[i] <= r_h[i];
            end
            S_COMPUTE: begin
               r_v[0] <= w_t1 + w_t2;
               r_v[1] <= r_v[0];
               r_v[2] <= r_v[1];
               r_v[3] <= r_v[2];
               r_v[4] <= r_v[3] + w_t1;
               r_v[5] <= r_v[4];
               r_v[6] <= r_v[5];
               r_v[7] <= r_v[6];
               for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
               r_w[15] <= w_wnew;
            end
            S_UPDATE: begin
               for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
               if (r_block != LAST_BLK) r_block <= r_block + 7'd1;
            end
            default: ;
         endcase
      end
   end
endmodule
